// File: rtl/ddr_pi_match_pkg.sv
// ---------------------------------------------------------------------------
// ddr_pi_match_pkg
// Shared definitions for the PI delay-match configuration sequencer:
//   - state_t   : sequencer state encoding
//   - pi_cfg_t  : packed view of the default-width cfg word {xcpl, gear, en}
//   - field offsets of EN / GEAR / XCPL inside the cfg word
// ---------------------------------------------------------------------------
package ddr_pi_match_pkg;

    // Default field widths of the cfg word
    localparam int PI_GWIDTH = 4;
    localparam int PI_XWIDTH = 4;

    // Field offsets inside the cfg word
    localparam int EN_BIT    = 0;
    localparam int GEAR_LSB  = 1;
    localparam int XCPL_LSB  = PI_GWIDTH + 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRAIN  = 3'd1,
        LOAD   = 3'd2,
        STEP   = 3'd3,
        SETTLE = 3'd4,
        DONE   = 3'd5
    } state_t;

    typedef struct packed {
        logic [PI_XWIDTH-1:0] xcpl;
        logic [PI_GWIDTH-1:0] gear;
        logic                 en;
    } pi_cfg_t;

endpackage

// File: rtl/ddr_pi_match_wait_cnt.sv
// ---------------------------------------------------------------------------
// ddr_pi_match_wait_cnt
// Load / count-down wait timer with a registered terminal-count flag.
// Used for the EN-low drain time, the settle time and XCPL step pacing.
// Ports:
//   clk       in  1       clock
//   rst       in  1       synchronous reset, active-high (count -> 0)
//   load      in  1       load load_val (has priority over dec)
//   load_val  in  CWIDTH  value loaded; the flag asserts after load_val decrements
//   dec       in  1       count down by one (saturates at zero)
//   cnt_zero  out 1       registered: current count equals zero
// ---------------------------------------------------------------------------
module ddr_pi_match_wait_cnt #(
    parameter int CWIDTH = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [CWIDTH-1:0] load_val,
    input  logic              dec,
    output logic              cnt_zero
);

    logic [CWIDTH-1:0] cnt_r;
    logic [CWIDTH-1:0] cnt_nxt_s;
    logic              zero_r;

    // Next count: load wins, otherwise saturating decrement
    always_comb begin
        cnt_nxt_s = cnt_r;
        if (load) begin
            cnt_nxt_s = load_val;
        end else if (dec && (cnt_r != {CWIDTH{1'b0}})) begin
            cnt_nxt_s = cnt_r - {{(CWIDTH-1){1'b0}}, 1'b1};
        end else begin
            cnt_nxt_s = cnt_r;
        end
    end

    // Count register and registered terminal-count flag
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r  <= {CWIDTH{1'b0}};
            zero_r <= 1'b1;
        end else begin
            cnt_r  <= cnt_nxt_s;
            zero_r <= (cnt_nxt_s == {CWIDTH{1'b0}});
        end
    end

    assign cnt_zero = zero_r;

endmodule

// File: rtl/ddr_pi_match_cfg_ctrl.sv
// ---------------------------------------------------------------------------
// ddr_pi_match_cfg_ctrl
// Sequencer that applies a new PI delay-match cfg word (EN/GEAR/XCPL)
// glitch-safely. GEAR or EN changes disable the PI, load the new code and
// re-enable it; XCPL-only changes walk XCPL one code at a time with EN kept
// high. o_done pulses once the output equals the accepted target.
// Ports:
//   i_clk     in   1       controller clock
//   i_rst     in   1       synchronous reset, active-high
//   i_req     in   1       update request, sampled only while o_ready=1
//   i_en      in   1       target EN
//   i_gear    in   GWIDTH  target GEAR
//   i_xcpl    in   XWIDTH  target XCPL
//   o_ready   out  1       idle, a request can be accepted
//   o_done    out  1       one-cycle pulse: o_pi_cfg equals the accepted target
//   o_pi_cfg  out  PWIDTH  registered cfg word {XCPL, GEAR, EN}
// ---------------------------------------------------------------------------
module ddr_pi_match_cfg_ctrl
    import ddr_pi_match_pkg::*;
#(
    parameter int GWIDTH     = PI_GWIDTH,
    parameter int XWIDTH     = PI_XWIDTH,
    parameter int PWIDTH     = $bits(pi_cfg_t),
    parameter int DIS_CYC    = 8,
    parameter int SETTLE_CYC = 16,
    parameter int STEP_CYC   = 4,
    parameter int CWIDTH     = 5
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req,
    input  logic              i_en,
    input  logic [GWIDTH-1:0] i_gear,
    input  logic [XWIDTH-1:0] i_xcpl,
    output logic              o_ready,
    output logic              o_done,
    output logic [PWIDTH-1:0] o_pi_cfg
);

    localparam int XLSB = GEAR_LSB + GWIDTH;

    // Timer reload values: a wait of N cycles loads N-1
    localparam logic [CWIDTH-1:0] DIS_LD    = CWIDTH'(DIS_CYC - 1);
    localparam logic [CWIDTH-1:0] SETTLE_LD = CWIDTH'(SETTLE_CYC - 1);
    localparam logic [CWIDTH-1:0] STEP_LD   = CWIDTH'(STEP_CYC - 1);

    state_t            state_r;
    state_t            state_nxt_s;
    logic [PWIDTH-1:0] cfg_r;
    logic [PWIDTH-1:0] cfg_nxt_s;
    logic [PWIDTH-1:0] tgt_r;
    logic              step_up_r;
    logic              ready_r;
    logic              done_r;

    logic              accept_s;
    logic [PWIDTH-1:0] req_cfg_s;
    logic              cur_en_s;
    logic [GWIDTH-1:0] cur_gear_s;
    logic [XWIDTH-1:0] cur_xcpl_s;
    logic              tgt_en_s;
    logic [GWIDTH-1:0] tgt_gear_s;
    logic [XWIDTH-1:0] tgt_xcpl_s;
    logic [XWIDTH-1:0] xcpl_step_s;

    logic              cnt_load_s;
    logic [CWIDTH-1:0] cnt_val_s;
    logic              cnt_dec_s;
    logic              cnt_zero_s;

    assign accept_s   = i_req & ready_r;
    assign req_cfg_s  = {i_xcpl, i_gear, i_en};

    assign cur_en_s   = cfg_r[EN_BIT];
    assign cur_gear_s = cfg_r[GEAR_LSB +: GWIDTH];
    assign cur_xcpl_s = cfg_r[XLSB +: XWIDTH];
    assign tgt_en_s   = tgt_r[EN_BIT];
    assign tgt_gear_s = tgt_r[GEAR_LSB +: GWIDTH];
    assign tgt_xcpl_s = tgt_r[XLSB +: XWIDTH];

    // One XCPL code toward the target; direction was fixed at accept, and the
    // walk stops on reaching the target, so it can never wrap.
    assign xcpl_step_s = step_up_r ? (cur_xcpl_s + {{(XWIDTH-1){1'b0}}, 1'b1})
                                   : (cur_xcpl_s - {{(XWIDTH-1){1'b0}}, 1'b1});

    ddr_pi_match_wait_cnt #(
        .CWIDTH   (CWIDTH)
    ) u_wait_cnt (
        .clk      (i_clk),
        .rst      (i_rst),
        .load     (cnt_load_s),
        .load_val (cnt_val_s),
        .dec      (cnt_dec_s),
        .cnt_zero (cnt_zero_s)
    );

    // Next state, next cfg word and timer control
    always_comb begin
        state_nxt_s = state_r;
        cfg_nxt_s   = cfg_r;
        cnt_load_s  = 1'b0;
        cnt_val_s   = {CWIDTH{1'b0}};
        cnt_dec_s   = 1'b0;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    if (req_cfg_s == cfg_r) begin
                        state_nxt_s = DONE;
                    end else if (cur_en_s && i_en && (i_gear == cur_gear_s)) begin
                        // Only XCPL differs: walk it with the PI enabled
                        state_nxt_s = STEP;
                        cnt_load_s  = 1'b1;
                        cnt_val_s   = STEP_LD;
                    end else if (cur_en_s) begin
                        state_nxt_s = DRAIN;
                        cnt_load_s  = 1'b1;
                        cnt_val_s   = DIS_LD;
                    end else begin
                        state_nxt_s = LOAD;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            DRAIN: begin
                cfg_nxt_s[EN_BIT] = 1'b0;
                if (cnt_zero_s) begin
                    state_nxt_s = LOAD;
                end else begin
                    cnt_dec_s = 1'b1;
                end
            end
            LOAD: begin
                // Code changes only while EN is low
                cfg_nxt_s[GEAR_LSB +: GWIDTH] = tgt_gear_s;
                cfg_nxt_s[XLSB +: XWIDTH]     = tgt_xcpl_s;
                if (tgt_en_s) begin
                    state_nxt_s = SETTLE;
                    cnt_load_s  = 1'b1;
                    cnt_val_s   = SETTLE_LD;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            STEP: begin
                if (cnt_zero_s) begin
                    cfg_nxt_s[XLSB +: XWIDTH] = xcpl_step_s;
                    cnt_load_s = 1'b1;
                    if (xcpl_step_s == tgt_xcpl_s) begin
                        state_nxt_s = SETTLE;
                        cnt_val_s   = SETTLE_LD;
                    end else begin
                        cnt_val_s   = STEP_LD;
                    end
                end else begin
                    cnt_dec_s = 1'b1;
                end
            end
            SETTLE: begin
                cfg_nxt_s[EN_BIT] = 1'b1;
                if (cnt_zero_s) begin
                    state_nxt_s = DONE;
                end else begin
                    cnt_dec_s = 1'b1;
                end
            end
            DONE: begin
                state_nxt_s = IDLE;
            end
            default: begin
                // Unreachable encoding: recover to a disabled, idle PI
                state_nxt_s = IDLE;
                cfg_nxt_s   = {PWIDTH{1'b0}};
            end
        endcase
    end

    // State, cfg word, captured target and registered handshake outputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_r   <= IDLE;
            cfg_r     <= {PWIDTH{1'b0}};
            tgt_r     <= {PWIDTH{1'b0}};
            step_up_r <= 1'b0;
            ready_r   <= 1'b1;
            done_r    <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            cfg_r   <= cfg_nxt_s;
            ready_r <= (state_nxt_s == IDLE);
            done_r  <= (state_r == DONE);
            if (accept_s) begin
                tgt_r     <= req_cfg_s;
                step_up_r <= (i_xcpl > cur_xcpl_s);
            end else begin
                tgt_r     <= tgt_r;
                step_up_r <= step_up_r;
            end
        end
    end

    assign o_pi_cfg = cfg_r;
    assign o_ready  = ready_r;
    assign o_done   = done_r;

endmodule

// File: tb/tb_ddr_pi_match_cfg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_ddr_pi_match_cfg_ctrl
// Self-checking bench: reset checks, a directed vector table with hand-derived
// final cfg and done latency, a reset-during-step sequence and randomized
// requests compared cycle by cycle against a timeline model built from the
// sequencing rules (drain / load / settle / step durations).
// ---------------------------------------------------------------------------
module tb_ddr_pi_match_cfg_ctrl;
    import ddr_pi_match_pkg::*;

    localparam int DIS = 8;
    localparam int SET = 16;
    localparam int STP = 4;

    logic       i_clk;
    logic       i_rst;
    logic       i_req;
    logic       i_en;
    logic [3:0] i_gear;
    logic [3:0] i_xcpl;
    logic       o_ready;
    logic       o_done;
    logic [8:0] o_pi_cfg;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [8:0] cfg;
        logic       done;
        logic       ready;
    } exp_t;

    typedef struct {
        logic       en;
        logic [3:0] gear;
        logic [3:0] xcpl;
        logic [8:0] cfg;
        int         lat;
    } vec_t;

    exp_t       exp_q[$];
    vec_t       vecs[9];
    logic [8:0] model_cur;

    ddr_pi_match_cfg_ctrl dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_req    (i_req),
        .i_en     (i_en),
        .i_gear   (i_gear),
        .i_xcpl   (i_xcpl),
        .o_ready  (o_ready),
        .o_done   (o_done),
        .o_pi_cfg (o_pi_cfg)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic void push(input logic [8:0] cfg, input logic d, input logic r);
        exp_t e;
        e.cfg   = cfg;
        e.done  = d;
        e.ready = r;
        exp_q.push_back(e);
    endfunction

    // Expected per-cycle outputs for t=1..end after accepting tgt from cur
    task automatic build_model(input logic [8:0] cur, input logic [8:0] tgt);
        pi_cfg_t c;
        pi_cfg_t t;
        pi_cfg_t w;
        int      d;
        c = cur;
        t = tgt;
        exp_q.delete();
        if (cur == tgt) begin
            push(cur, 1'b1, 1'b1);
        end else if (c.en && t.en && (c.gear == t.gear)) begin
            d = (t.xcpl > c.xcpl) ? int'(t.xcpl) - int'(c.xcpl) : int'(c.xcpl) - int'(t.xcpl);
            for (int k = 1; k <= d * STP; k++) begin
                w = c;
                if (t.xcpl > c.xcpl) w.xcpl = 4'(int'(c.xcpl) + k / STP);
                else                 w.xcpl = 4'(int'(c.xcpl) - k / STP);
                push(w, 1'b0, 1'b0);
            end
            repeat (SET) push(t, 1'b0, 1'b0);
            push(t, 1'b1, 1'b1);
        end else begin
            w = c;
            if (c.en) begin
                w.en = 1'b0;
                repeat (DIS) push(w, 1'b0, 1'b0);
            end
            w.xcpl = t.xcpl;
            w.gear = t.gear;
            w.en   = 1'b0;
            push(w, 1'b0, 1'b0);
            if (t.en) repeat (SET) push(t, 1'b0, 1'b0);
            push(t, 1'b1, 1'b1);
        end
    endtask

    // Present a request, then follow the model cycle by cycle while the
    // inputs are scrambled (busy requests must be ignored)
    task automatic run_txn(input logic en, input logic [3:0] g, input logic [3:0] x,
                           output int done_t);
        logic [8:0] tgt;
        tgt    = {x, g, en};
        done_t = -1;
        build_model(model_cur, tgt);
        i_req  = 1'b1;
        i_en   = en;
        i_gear = g;
        i_xcpl = x;
        @(posedge i_clk);
        #1;
        chk("ready_after_accept", 32'(o_ready), 32'd0);
        for (int t = 1; t <= exp_q.size(); t++) begin
            i_req  = 1'($urandom_range(0, 1));
            i_en   = 1'($urandom_range(0, 1));
            i_gear = 4'($urandom_range(0, 15));
            i_xcpl = 4'($urandom_range(0, 15));
            if (t == exp_q.size()) i_req = 1'b0;
            @(posedge i_clk);
            #1;
            chk($sformatf("cfg t=%0d", t),   32'(o_pi_cfg), 32'(exp_q[t-1].cfg));
            chk($sformatf("done t=%0d", t),  32'(o_done),   32'(exp_q[t-1].done));
            chk($sformatf("ready t=%0d", t), 32'(o_ready),  32'(exp_q[t-1].ready));
            if (o_done === 1'b1 && done_t < 0) done_t = t;
        end
        i_req     = 1'b0;
        model_cur = tgt;
    endtask

    task automatic idle_cycles(input int n);
        i_req = 1'b0;
        repeat (n) begin
            @(posedge i_clk);
            #1;
            chk("idle_cfg",   32'(o_pi_cfg), 32'(model_cur));
            chk("idle_ready", 32'(o_ready),  32'd1);
            chk("idle_done",  32'(o_done),   32'd0);
        end
    endtask

    task automatic do_reset();
        i_rst  = 1'b1;
        i_req  = 1'b1;
        i_en   = 1'b1;
        i_gear = 4'd7;
        i_xcpl = 4'd2;
        repeat (2) begin
            @(posedge i_clk);
            #1;
            chk("rst_cfg",   32'(o_pi_cfg), 32'd0);
            chk("rst_ready", 32'(o_ready),  32'd1);
            chk("rst_done",  32'(o_done),   32'd0);
        end
        i_rst     = 1'b0;
        i_req     = 1'b0;
        model_cur = 9'h000;
        idle_cycles(2);
    endtask

    initial begin
        int         dt;
        int         r;
        logic       en;
        logic [3:0] g;
        logic [3:0] x;
        pi_cfg_t    cf;

        vecs[0] = '{1'b1, 4'd3,  4'd5,  9'h0A7, 18};
        vecs[1] = '{1'b1, 4'd3,  4'd9,  9'h127, 33};
        vecs[2] = '{1'b1, 4'd4,  4'd9,  9'h129, 26};
        vecs[3] = '{1'b1, 4'd4,  4'd9,  9'h129, 1};
        vecs[4] = '{1'b1, 4'd4,  4'd7,  9'h0E9, 25};
        vecs[5] = '{1'b0, 4'd4,  4'd7,  9'h0E8, 10};
        vecs[6] = '{1'b0, 4'd2,  4'd0,  9'h004, 2};
        vecs[7] = '{1'b1, 4'd15, 4'd15, 9'h1FF, 18};
        vecs[8] = '{1'b1, 4'd15, 4'd0,  9'h01F, 77};

        i_rst     = 1'b1;
        i_req     = 1'b0;
        i_en      = 1'b0;
        i_gear    = 4'd0;
        i_xcpl    = 4'd0;
        model_cur = 9'h000;

        do_reset();

        for (int v = 0; v < 9; v++) begin
            run_txn(vecs[v].en, vecs[v].gear, vecs[v].xcpl, dt);
            chk($sformatf("vec%0d_latency", v), 32'(dt), 32'(vecs[v].lat));
            chk($sformatf("vec%0d_cfg", v), 32'(o_pi_cfg), 32'(vecs[v].cfg));
            idle_cycles(1);
        end

        // Reset in the middle of an XCPL walk
        do_reset();
        run_txn(1'b1, 4'd3, 4'd5, dt);
        idle_cycles(1);
        build_model(model_cur, 9'h127);
        i_req  = 1'b1;
        i_en   = 1'b1;
        i_gear = 4'd3;
        i_xcpl = 4'd9;
        @(posedge i_clk);
        #1;
        i_req = 1'b0;
        for (int t = 1; t <= 5; t++) begin
            @(posedge i_clk);
            #1;
            chk($sformatf("midstep cfg t=%0d", t), 32'(o_pi_cfg), 32'(exp_q[t-1].cfg));
        end
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        chk("midrst_cfg",   32'(o_pi_cfg), 32'd0);
        chk("midrst_ready", 32'(o_ready),  32'd1);
        chk("midrst_done",  32'(o_done),   32'd0);
        i_rst     = 1'b0;
        model_cur = 9'h000;
        idle_cycles(20);

        // Randomized requests, biased toward equal and XCPL-only targets
        for (int n = 0; n < 40; n++) begin
            cf = model_cur;
            r  = $urandom_range(0, 9);
            if (r < 2) begin
                en = cf.en;
                g  = cf.gear;
                x  = cf.xcpl;
            end else if (r < 5 && cf.en) begin
                en = 1'b1;
                g  = cf.gear;
                x  = 4'($urandom_range(0, 15));
            end else begin
                en = 1'($urandom_range(0, 1));
                g  = 4'($urandom_range(0, 15));
                x  = 4'($urandom_range(0, 15));
            end
            run_txn(en, g, x, dt);
            idle_cycles($urandom_range(1, 3));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
